// File: rtl/xm23_branch_pkg.sv
// ============================================================================
// Module : xm23_branch_pkg
// Brief  : Shared types and defaults for the branch recovery controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package xm23_branch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } brc_state_t;

  localparam int PC_W_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/fallthru_fifo.sv
// ============================================================================
// Module : fallthru_fifo
// Brief  : In-order buffer of predicted-branch fall-through PCs; clear wins over push.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fallthru_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i && !rst) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/branch_recovery_ctrl.sv
// ============================================================================
// Module : branch_recovery_ctrl
// Brief  : Misprediction recovery sequencer for predict-taken conditional branches.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_recovery_ctrl
  import xm23_branch_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = PC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       br_issue_i,
  input  logic [PC_W-1:0]            br_fallthru_i,
  input  logic                       br_resolve_i,
  input  logic                       branch_fail_i,
  output logic                       pc_load_o,
  output logic [PC_W-1:0]            pc_load_val_o,
  output logic                       flush_o,
  output logic                       fetch_hold_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic [15:0]                mispredict_cnt_o,
  output logic                       err_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int FC_W  = $clog2(FLUSH_CYCLES+1);

  brc_state_t       state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             pc_load_q, pc_load_d;
  logic [PC_W-1:0]  pc_val_q, pc_val_d;
  logic [15:0]      mispredict_cnt_q, mispredict_cnt_d;
  logic             err_q, err_d;

  logic             fifo_push, fifo_pop, fifo_clear;
  logic [PC_W-1:0]  fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  fallthru_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (br_fallthru_i),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      fcnt_q           <= '0;
      pc_load_q        <= 1'b0;
      pc_val_q         <= '0;
      mispredict_cnt_q <= '0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      pc_load_q        <= pc_load_d;
      pc_val_q         <= pc_val_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      err_q            <= err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    pc_load_d        = 1'b0;
    pc_val_d         = pc_val_q;
    mispredict_cnt_d = mispredict_cnt_q;
    err_d            = err_q;
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    fifo_clear       = 1'b0;

    case (state_q)
      S_FLUSH: begin
        // Decode and execute traffic in this window belongs to the squashed path.
        fcnt_d = fcnt_q - FC_W'(1);
        if (fcnt_q == FC_W'(1)) state_d = S_IDLE;
      end
      default: begin
        if (br_resolve_i && !fifo_empty) begin
          if (branch_fail_i) begin
            fifo_clear = 1'b1;
            pc_load_d  = 1'b1;
            pc_val_d   = fifo_head;
            if (mispredict_cnt_q != 16'hFFFF) mispredict_cnt_d = mispredict_cnt_q + 16'd1;
            state_d    = S_FLUSH;
            fcnt_d     = FC_W'(FLUSH_CYCLES);
          end else begin
            fifo_pop  = 1'b1;
            fifo_push = br_issue_i;
            state_d   = (fifo_count == CNT_W'(1) && !br_issue_i) ? S_IDLE : S_PEND;
          end
        end else begin
          if (br_resolve_i) err_d = 1'b1;
          if (br_issue_i) begin
            if (fifo_full) begin
              err_d = 1'b1;
            end else begin
              fifo_push = 1'b1;
              state_d   = S_PEND;
            end
          end
        end
      end
    endcase
  end

  assign pc_load_o        = pc_load_q;
  assign pc_load_val_o    = pc_val_q;
  assign flush_o          = (state_q == S_FLUSH);
  assign fetch_hold_o     = fifo_full || (state_q == S_FLUSH);
  assign outstanding_o    = fifo_count;
  assign mispredict_cnt_o = mispredict_cnt_q;
  assign err_o            = err_q;

endmodule

`default_nettype wire
